// File: rtl/spi_pkg.sv
// Shared SPI definitions: payload width, mode-0 constants and the master FSM encoding.
package spi_pkg;

   localparam int unsigned SPI_WIDTH = 8;
   localparam int unsigned BIT_CW    = 3;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEAD  = 3'd1;
   localparam logic [2:0] ST_XFER  = 3'd2;
   localparam logic [2:0] ST_TRAIL = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer: alternates low/high phases of CLK_DIV cycles and strobes at each phase end.
module spi_sck_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          phase;

   // phase 0 = sck low half, phase 1 = sck high half
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

   always_comb begin
      rise_tick = 1'b0;
      fall_tick = 1'b0;
      if (en && (cnt == LAST)) begin
         rise_tick = ~phase;
         fall_tick = phase;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte per start, MSB first, fully registered sck/ss/mosi.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [SPI_WIDTH-1:0] din,
   output logic [SPI_WIDTH-1:0] dout,
   output logic                 busy,
   output logic                 done,
   output logic                 ss,
   output logic                 sck,
   output logic                 mosi,
   input  logic                 miso
);

   localparam logic SAMPLE_ON_RISE = (SPI_CPHA == SPI_CPOL);
   localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(SPI_WIDTH - 1);

   logic [2:0]           state_q;
   logic [2:0]           state_d;
   logic [SPI_WIDTH-1:0] tx;
   logic [SPI_WIDTH-1:0] rx;
   logic [BIT_CW-1:0]    bit_cnt;
   logic                 gen_en_c;
   logic                 rise_tick;
   logic                 fall_tick;
   logic                 sample_c;
   logic                 last_c;

   assign gen_en_c = (state_q == ST_LEAD) || (state_q == ST_XFER) || (state_q == ST_TRAIL);
   assign sample_c = SAMPLE_ON_RISE ? rise_tick : fall_tick;
   assign last_c   = (bit_cnt == LAST_BIT);

   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (gen_en_c),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // The 9th low->high strobe ends XFER without raising sck; TRAIL ends on the next phase change.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)               state_d = ST_LEAD;
         ST_LEAD:  if (rise_tick)           state_d = ST_XFER;
         ST_XFER:  if (rise_tick && last_c) state_d = ST_TRAIL;
         ST_TRAIL: if (fall_tick)           state_d = ST_DONE;
         ST_DONE:                           state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx      <= '0;
         rx      <= '0;
         bit_cnt <= '0;
         dout    <= '0;
         ss      <= 1'b1;
         sck     <= SPI_CPOL;
         mosi    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  tx      <= din;
                  rx      <= '0;
                  bit_cnt <= '0;
                  ss      <= 1'b0;
                  busy    <= 1'b1;
                  mosi    <= din[SPI_WIDTH-1];
               end
            end
            ST_LEAD: begin
               if (rise_tick) sck <= ~SPI_CPOL;
               if (sample_c)  rx  <= {rx[SPI_WIDTH-2:0], miso};
            end
            ST_XFER: begin
               if (rise_tick && !last_c) begin
                  sck     <= ~SPI_CPOL;
                  bit_cnt <= bit_cnt + 1'b1;
               end
               if (sample_c && !last_c) rx <= {rx[SPI_WIDTH-2:0], miso};
               if (fall_tick) begin
                  sck <= SPI_CPOL;
                  if (!last_c) begin
                     tx   <= tx << 1;
                     mosi <= tx[SPI_WIDTH-2];
                  end
               end
            end
            ST_TRAIL: begin
               if (fall_tick) begin
                  done <= 1'b1;
                  ss   <= 1'b1;
                  mosi <= 1'b0;
                  dout <= rx;
               end
            end
            ST_DONE: begin
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: cycle-level reference model for CLK_DIV=2 and 1 plus directed literal checks.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] din;
   logic       miso0, miso1;
   logic [7:0] dout [2];
   logic       busy [2], done [2], ss [2], sck [2], mosi [2];

   int         mode = 0;  // dut0 miso source: 0 loopback, 1 const 0, 2 const 1, 3 slave
   logic       slv_miso = 1'b0;
   logic [7:0] s_sh = 8'h00, s_rx = 8'h00;
   int         s_bits = 0, s_done = 0;

   int pass_cnt = 0, total_cnt = 0;
   bit chk_en = 1'b0;

   int         dv [2] = '{2, 1};
   int         n  [2] = '{0, 0};
   logic [7:0] mtx [2], mrx [2], edout [2];

   assign miso0 = (mode == 0) ? mosi[0] : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : slv_miso;
   assign miso1 = mosi[1];

   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(2)) dut0 (
      .clk(clk), .rst(rst), .start(start), .din(din), .dout(dout[0]), .busy(busy[0]),
      .done(done[0]), .ss(ss[0]), .sck(sck[0]), .mosi(mosi[0]), .miso(miso0));

   spi_master #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .din(din), .dout(dout[1]), .busy(busy[1]),
      .done(done[1]), .ss(ss[1]), .sck(sck[1]), .mosi(mosi[1]), .miso(miso1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Expected {busy, ss, sck, mosi, done} in cycle n after acceptance (n=0 means idle).
   function automatic logic [4:0] exp_sig(input int d, input int cyc, input logic [7:0] tx);
      int   tot, b;
      logic s, m;
      tot = 18 * d + 1;
      if (cyc == 0) return 5'b01000;
      s = 1'b0;
      if (cyc >= d + 1 && cyc <= 17 * d) s = (((cyc - d - 1) % (2 * d)) < d);
      b = (cyc < 2 * d + 1) ? 0 : (cyc - 2 * d - 1) / (2 * d) + 1;
      if (b > 7) b = 7;
      m = (cyc == tot) ? 1'b0 : tx[7 - b];
      return {1'b1, cyc == tot, s, m, cyc == tot};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            n[i] = 0;
            edout[i] = 8'h00;
         end else if (n[i] > 0) begin
            if (n[i] == 18 * dv[i] + 1) n[i] = 0;
            else begin
               n[i]++;
               if (n[i] == 18 * dv[i] + 1) edout[i] = mrx[i];
            end
         end else if (start) begin
            n[i] = 1;
            mtx[i] = din;
            mrx[i] = 8'h00;
         end
      end
   end

   // Per-cycle compare; miso is captured in the model during the cycle before each sck rise.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (chk_en) begin
            chk($sformatf("sig%0d n=%0d", i, n[i]), {27'd0, busy[i], ss[i], sck[i], mosi[i], done[i]},
                {27'd0, exp_sig(dv[i], n[i], mtx[i])});
            chk($sformatf("dout%0d n=%0d", i, n[i]), {24'd0, dout[i]}, {24'd0, edout[i]});
         end
         if (n[i] >= dv[i] && ((n[i] - dv[i]) % (2 * dv[i])) == 0 && ((n[i] - dv[i]) / (2 * dv[i])) < 8)
            mrx[i] = {mrx[i][6:0], (i == 0) ? miso0 : miso1};
      end
   end

   // Behavioural mode-0 slave on dut0
   always @(negedge ss[0]) if (mode == 3) begin slv_miso = s_sh[7]; s_bits = 0; end
   always @(posedge sck[0]) if (mode == 3 && !ss[0]) begin s_rx = {s_rx[6:0], mosi[0]}; s_bits++; end
   always @(negedge sck[0]) if (mode == 3 && !ss[0] && s_bits < 8) begin s_sh = s_sh << 1; slv_miso = s_sh[7]; end
   always @(posedge ss[0]) if (mode == 3 && s_bits == 8) s_done++;

   task automatic xfer(input logic [7:0] d, output int dc0, output int dc1, output int rises0, output int per1);
      logic p0, p1;
      int   r1a, r1b;
      dc0 = -1; dc1 = -1; rises0 = 0; r1a = -1; r1b = -1; p0 = 1'b0; p1 = 1'b0;
      @(negedge clk);
      start = 1'b1; din = d;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin start = 1'b0; din = ~d; end
         if (done[0] && dc0 < 0) dc0 = k;
         if (done[1] && dc1 < 0) dc1 = k;
         if (sck[0] && !p0) rises0++;
         if (sck[1] && !p1) begin if (r1a < 0) r1a = k; else if (r1b < 0) r1b = k; end
         p0 = sck[0]; p1 = sck[1];
         if (dc0 >= 0 && k > dc0) break;
      end
      per1 = r1b - r1a;
   endtask

   initial begin
      int dc0, dc1, r0, p1, dn;
      rst = 1'b1; start = 1'b0; din = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset ss", {31'd0, ss[0]}, 32'd1);
      chk("reset sck/mosi/busy/done", {28'd0, sck[0], mosi[0], busy[0], done[0]}, 32'd0);
      chk("reset dout", {24'd0, dout[0]}, 32'h00);
      chk_en = 1'b1; rst = 1'b0;
      @(negedge clk);

      xfer(8'hA5, dc0, dc1, r0, p1);
      chk("loop A5 dout", {24'd0, dout[0]}, 32'hA5);
      chk("loop A5 done cycle", dc0, 37);
      chk("loop A5 sck rises", r0, 8);

      xfer(8'h5A, dc0, dc1, r0, p1);
      chk("div1 5A dout", {24'd0, dout[1]}, 32'h5A);
      chk("div1 done cycle", dc1, 19);
      chk("div1 sck period", p1, 2);

      mode = 2;
      xfer(8'h00, dc0, dc1, r0, p1);
      chk("miso=1 dout", {24'd0, dout[0]}, 32'hFF);
      mode = 1;
      xfer(8'hFF, dc0, dc1, r0, p1);
      chk("miso=0 dout", {24'd0, dout[0]}, 32'h00);

      mode = 3; s_sh = 8'hC3; s_rx = 8'h00; s_done = 0;
      xfer(8'h3C, dc0, dc1, r0, p1);
      chk("slave master dout", {24'd0, dout[0]}, 32'hC3);
      chk("slave rx", {24'd0, s_rx}, 32'h3C);
      chk("slave done count", s_done, 1);
      mode = 0;

      // start re-asserted while busy and in DONE, then accepted at cycle 38
      for (int k = 0; k <= 45; k++) begin
         @(negedge clk);
         if (k == 5)  chk("busy start ignored", {31'd0, busy[0]}, 32'd1);
         if (k == 37) chk("busy done@37", {30'd0, done[0], ss[0]}, 32'd3);
         if (k == 38) chk("busy ss@38", {31'd0, ss[0]}, 32'd1);
         if (k == 39) chk("busy ss/busy@39", {30'd0, ss[0], busy[0]}, 32'd1);
         start = (k == 0 || k == 5 || k == 37 || k == 38);
         din = (k == 38) ? 8'h42 : 8'h81;
      end
      start = 1'b0;
      repeat (50) @(negedge clk);
      chk("restart dout", {24'd0, dout[0]}, 32'h42);
      chk("div1 restart dout", {24'd0, dout[1]}, 32'h81);

      // reset in the middle of a transfer
      for (int k = 0; k <= 11; k++) begin
         @(negedge clk);
         if (k == 11) begin
            chk("midrst ss/sck/busy/done", {28'd0, ss[0], sck[0], busy[0], done[0]}, 32'h8);
            chk("midrst dout", {24'd0, dout[0]}, 32'h00);
         end
         start = (k == 0);
         if (k == 0) din = 8'h99;
         rst = (k == 10);
      end
      dn = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done[0]) dn++;
      end
      chk("midrst no done", dn, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
